data_cache_ctrl: RTL and testbench

Controller for the associative processor's single-line data cache. Accepts word read/write requests from the instruction/datapath side, serves hits from a DATA_CACHE_DEPTH-word line held in registers, and on a miss writes the dirty line back and refills it from DDR with burst transfers. Sits between the AP load/store path and the DDR burst controller.

---
 rtl/ap_cache_pkg.sv | 30 +++
 rtl/data_cache_line_ram.sv | 37 +++
 rtl/data_cache_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_cache_pkg.sv
// ============================================================================
// Module  : ap_cache_pkg
// Brief   : Shared types and constants for the AP single-line data cache.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ap_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_RESP    = 3'd2,
        S_WB_REQ  = 3'd3,
        S_WB_DATA = 3'd4,
        S_RD_REQ  = 3'd5,
        S_RD_DATA = 3'd6
    } cache_state_t;

    // DDR is byte-addressed with 8 bytes per cache word
    localparam int DDR_WORD_SHIFT  = 3;
    localparam int BURST_LEN_WIDTH = 10;

    function automatic logic [BURST_LEN_WIDTH-1:0] burst_len(input int depth);
        return BURST_LEN_WIDTH'(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_cache_line_ram.sv
// ============================================================================
// Module  : data_cache_line_ram
// Brief   : Register array holding the resident line; one write port, two
//           combinational read ports (response and write-back).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module data_cache_line_ram #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr_resp,
    output logic [DATA_WIDTH-1:0] o_rdata_resp,
    input  logic [IDX_W-1:0]      i_raddr_wb,
    output logic [DATA_WIDTH-1:0] o_rdata_wb
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_resp = r_mem[i_raddr_resp];
    assign o_rdata_wb   = r_mem[i_raddr_wb];

endmodule

`default_nettype wire

// File: rtl/data_cache_ctrl.sv
// ============================================================================
// Module  : data_cache_ctrl
// Brief   : Single-line data cache controller with DDR write-back and refill.
// Options : DATA_CACHE_PERF_EN adds saturating hit_cnt/miss_cnt outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module data_cache_ctrl
    import ap_cache_pkg::*;
#(
    parameter int DATA_CACHE_DEPTH = 16,
    parameter int DATA_WIDTH       = 16,
    parameter int DDR_ADDR_WIDTH   = 28,
    parameter int ADDR_WIDTH_MEM   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_req,
    input  logic                      data_we,
    input  logic [ADDR_WIDTH_MEM-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]     data_wr,
    output logic                      data_rdy,
    output logic                      data_out_valid,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [ADDR_WIDTH_MEM-1:0] tag_data,
    output logic                      rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [9:0]                rd_burst_len,
    input  logic                      rd_burst_data_valid,
    input  logic [DATA_WIDTH-1:0]     rd_burst_data,
    input  logic                      rd_burst_finish,
    output logic                      wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    output logic [9:0]                wr_burst_len,
    input  logic                      wr_burst_data_req,
    output logic [DATA_WIDTH-1:0]     wr_burst_data,
    input  logic                      wr_burst_finish
`ifdef DATA_CACHE_PERF_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);

    localparam int c_IDX_W = (DATA_CACHE_DEPTH > 1) ? $clog2(DATA_CACHE_DEPTH) : 1;

    cache_state_t r_state, w_next_state;

    logic [ADDR_WIDTH_MEM-1:0] r_addr, r_tag;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_we, r_valid, r_dirty;
    logic [c_IDX_W-1:0]        r_store_cnt;
    logic [c_IDX_W:0]          r_rd_cnt;

    logic [ADDR_WIDTH_MEM:0]   w_addr_ext, w_tag_ext, w_tag_end;
    logic                      w_hit, w_in_wb, w_in_rd, w_refill_we, w_line_we;
    logic [c_IDX_W-1:0]        w_index, w_line_waddr;
    logic [DATA_WIDTH-1:0]     w_line_wdata, w_rd_resp, w_rd_wb;

    // One extra bit keeps tag+DEPTH from wrapping at the top of the address space
    assign w_addr_ext = {1'b0, r_addr};
    assign w_tag_ext  = {1'b0, r_tag};
    assign w_tag_end  = w_tag_ext + (ADDR_WIDTH_MEM+1)'(DATA_CACHE_DEPTH);
    assign w_hit      = r_valid && (w_addr_ext >= w_tag_ext) && (w_addr_ext < w_tag_end);
    assign w_index    = c_IDX_W'(r_addr - r_tag);

    assign w_in_wb     = (r_state == S_WB_REQ) || (r_state == S_WB_DATA);
    assign w_in_rd     = (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
    assign w_refill_we = w_in_rd && rd_burst_data_valid && !r_rd_cnt[c_IDX_W];

    always_comb begin
        w_line_we    = 1'b0;
        w_line_waddr = w_index;
        w_line_wdata = r_wdata;
        if (r_state == S_RESP && r_we) begin
            w_line_we = 1'b1;
        end else if (w_refill_we) begin
            w_line_we    = 1'b1;
            w_line_waddr = r_rd_cnt[c_IDX_W-1:0];
            w_line_wdata = rd_burst_data;
        end
    end

    data_cache_line_ram #(
        .DEPTH      (DATA_CACHE_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (c_IDX_W)
    ) u_line_ram (
        .clk          (clk),
        .i_we         (w_line_we),
        .i_waddr      (w_line_waddr),
        .i_wdata      (w_line_wdata),
        .i_raddr_resp (w_index),
        .o_rdata_resp (w_rd_resp),
        .i_raddr_wb   (r_store_cnt),
        .o_rdata_wb   (w_rd_wb)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (data_req) w_next_state = S_LOOKUP;
            S_LOOKUP: begin
                if (w_hit)                 w_next_state = S_RESP;
                else if (r_valid && r_dirty) w_next_state = S_WB_REQ;
                else                       w_next_state = S_RD_REQ;
            end
            S_RESP:    w_next_state = S_IDLE;
            S_WB_REQ:  if (wr_burst_data_req)   w_next_state = S_WB_DATA;
            S_WB_DATA: if (wr_burst_finish)     w_next_state = S_RD_REQ;
            S_RD_REQ:  if (rd_burst_data_valid) w_next_state = S_RD_DATA;
            S_RD_DATA: if (rd_burst_finish)     w_next_state = S_LOOKUP;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_tag       <= '0;
            r_valid     <= 1'b0;
            r_dirty     <= 1'b0;
            r_store_cnt <= '0;
            r_rd_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && data_req) begin
                r_addr  <= data_addr;
                r_we    <= data_we;
                r_wdata <= data_wr;
            end
            if (r_state == S_RESP && r_we) begin
                r_dirty <= 1'b1;
            end
            if (w_in_wb && wr_burst_data_req) begin
                r_store_cnt <= r_store_cnt + 1'b1;
            end
            if (r_state == S_WB_DATA && wr_burst_finish) begin
                r_dirty     <= 1'b0;
                r_store_cnt <= '0;
            end
            // Line is being overwritten; it is not valid until the refill completes
            if (r_state == S_RD_REQ) begin
                r_valid <= 1'b0;
            end
            if (w_refill_we) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (r_state == S_RD_DATA && rd_burst_finish) begin
                r_tag    <= r_addr;
                r_valid  <= 1'b1;
                r_dirty  <= 1'b0;
                r_rd_cnt <= '0;
            end
        end
    end

    assign data_rdy       = (r_state == S_IDLE);
    assign data_out_valid = (r_state == S_RESP);
    assign data_out       = (r_state == S_RESP && !r_we) ? w_rd_resp : '0;
    assign tag_data       = r_tag;

    assign rd_burst_req  = (r_state == S_RD_REQ);
    assign rd_burst_addr = rd_burst_req ? (DDR_ADDR_WIDTH'(r_addr) << DDR_WORD_SHIFT) : '0;
    assign rd_burst_len  = rd_burst_req ? burst_len(DATA_CACHE_DEPTH) : '0;

    assign wr_burst_req  = (r_state == S_WB_REQ);
    assign wr_burst_addr = wr_burst_req ? (DDR_ADDR_WIDTH'(r_tag) << DDR_WORD_SHIFT) : '0;
    assign wr_burst_len  = wr_burst_req ? burst_len(DATA_CACHE_DEPTH) : '0;
    assign wr_burst_data = w_in_wb ? w_rd_wb : '0;

`ifdef DATA_CACHE_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;
    logic        r_first;

    // Only the first lookup of a request counts; the post-refill lookup is skipped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_first    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && data_req) begin
                r_first <= 1'b1;
            end
            if (r_state == S_LOOKUP) begin
                r_first <= 1'b0;
                if (r_first && w_hit && r_hit_cnt != '1) begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
                if (r_first && !w_hit && r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    // Counters are not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_cache_ctrl.sv
// ============================================================================
// Module  : tb_data_cache_ctrl
// Brief   : Directed self-checking bench for data_cache_ctrl.
// Options : DATA_CACHE_PERF_EN enables hit/miss counter checks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_req = 1'b0, data_we = 1'b0;
    logic [15:0] data_addr = '0, data_wr = '0;
    logic        data_rdy, data_out_valid;
    logic [15:0] data_out, tag_data;
    logic        rd_burst_req, wr_burst_req;
    logic [27:0] rd_burst_addr, wr_burst_addr;
    logic [9:0]  rd_burst_len, wr_burst_len;
    logic        rd_burst_data_valid = 1'b0, rd_burst_finish = 1'b0;
    logic [15:0] rd_burst_data = '0;
    logic        wr_burst_data_req = 1'b0, wr_burst_finish = 1'b0;
    logic [15:0] wr_burst_data;
`ifdef DATA_CACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int          passes = 0;
    int          fails  = 0;
    int          total  = 0;
    logic [15:0] wb_beats [16];

    always #5 clk = ~clk;

    data_cache_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_req            (data_req),
        .data_we             (data_we),
        .data_addr           (data_addr),
        .data_wr             (data_wr),
        .data_rdy            (data_rdy),
        .data_out_valid      (data_out_valid),
        .data_out            (data_out),
        .tag_data            (tag_data),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish)
`ifdef DATA_CACHE_PERF_EN
        ,
        .hit_cnt             (hit_cnt),
        .miss_cnt            (miss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        check("rdy_before_req", {31'b0, data_rdy}, 32'd1);
        data_req  = 1'b1;
        data_we   = we;
        data_addr = addr;
        data_wr   = wdata;
        step();
        data_req  = 1'b0;
        data_we   = 1'b0;
    endtask

    task automatic refill(input logic [27:0] exp_addr, input logic [15:0] base,
                          input int gap, input int extra);
        int n = 0;
        while (rd_burst_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("rd_req", {31'b0, rd_burst_req}, 32'd1);
        check("rd_addr", {4'b0, rd_burst_addr}, {4'b0, exp_addr});
        check("rd_len", {22'b0, rd_burst_len}, 32'd16);
        for (int k = 0; k < 16 + extra; k++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data       = base + 16'(k);
            step();
            rd_burst_data_valid = 1'b0;
            repeat (gap) step();
        end
        rd_burst_finish = 1'b1;
        step();
        rd_burst_finish = 1'b0;
    endtask

    task automatic writeback(input logic [27:0] exp_addr);
        int n = 0;
        while (wr_burst_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("wb_req", {31'b0, wr_burst_req}, 32'd1);
        check("wb_addr", {4'b0, wr_burst_addr}, {4'b0, exp_addr});
        check("wb_len", {22'b0, wr_burst_len}, 32'd16);
        repeat (2) step();
        check("wb_req_held", {31'b0, wr_burst_req}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            wr_burst_data_req = 1'b1;
            wb_beats[k] = wr_burst_data;
            step();
            wr_burst_data_req = 1'b0;
            if (k == 0) check("wb_req_dropped", {31'b0, wr_burst_req}, 32'd0);
            if (k % 2 == 1) step();
        end
        wr_burst_finish = 1'b1;
        step();
        wr_burst_finish = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_rdy", {31'b0, data_rdy}, 32'd1);
        check("rst_valid", {31'b0, data_out_valid}, 32'd0);
        check("rst_rd_req", {31'b0, rd_burst_req}, 32'd0);
        check("rst_wr_req", {31'b0, wr_burst_req}, 32'd0);
        check("rst_tag", {16'b0, tag_data}, 32'd0);
        rst = 1'b1;
        step();

        // Cold read miss at 0x0040
        request(1'b0, 16'h0040, 16'h0);
        refill(28'h0000200, 16'h1000, 0, 0);
        check("cold_lookup_no_valid", {31'b0, data_out_valid}, 32'd0);
        step();
        check("cold_valid", {31'b0, data_out_valid}, 32'd1);
        check("cold_data", {16'b0, data_out}, 32'h1000);
        check("cold_tag", {16'b0, tag_data}, 32'h0040);
        step();

        // Hit on the last word of the line, T+2 latency
        request(1'b0, 16'h004F, 16'h0);
        check("hit_no_rd_req", {31'b0, rd_burst_req}, 32'd0);
        check("hit_lookup_no_valid", {31'b0, data_out_valid}, 32'd0);
        step();
        check("hit_valid", {31'b0, data_out_valid}, 32'd1);
        check("hit_data", {16'b0, data_out}, 32'h100F);
        step();

        // One past the line end: clean miss, no write-back
        request(1'b0, 16'h0050, 16'h0);
        step();
        check("clean_no_wb", {31'b0, wr_burst_req}, 32'd0);
        refill(28'h0000280, 16'h2000, 0, 0);
        step();
        check("m50_data", {16'b0, data_out}, 32'h2000);
        check("m50_tag", {16'b0, tag_data}, 32'h0050);
        step();

        // Write hit at index 5 makes the line dirty
        request(1'b1, 16'h0055, 16'hBEEF);
        step();
        check("wr_valid", {31'b0, data_out_valid}, 32'd1);
        step();

        // Dirty miss: write-back then gapped refill with a stray 17th beat
        request(1'b0, 16'h0100, 16'h0);
        writeback(28'h0000280);
        check("wb_beat0", {16'b0, wb_beats[0]}, 32'h2000);
        check("wb_beat5", {16'b0, wb_beats[5]}, 32'hBEEF);
        check("wb_beat15", {16'b0, wb_beats[15]}, 32'h200F);
        refill(28'h0000800, 16'h3000, 2, 1);
        step();
        check("m100_valid", {31'b0, data_out_valid}, 32'd1);
        check("m100_data_stray_ignored", {16'b0, data_out}, 32'h3000);
        check("m100_tag", {16'b0, tag_data}, 32'h0100);
`ifdef DATA_CACHE_PERF_EN
        check("perf_hits", hit_cnt, 32'd2);
        check("perf_misses", miss_cnt, 32'd3);
`endif
        step();

        // Every word of the gapped refill
        for (int k = 0; k < 16; k++) begin
            request(1'b0, 16'h0100 + 16'(k), 16'h0);
            check("gap_no_rd_req", {31'b0, rd_burst_req}, 32'd0);
            step();
            check("gap_word", {16'b0, data_out}, 32'h3000 + k);
            step();
        end

        // Reset during refill beat 7
        request(1'b0, 16'h0200, 16'h0);
        step();
        check("r200_rd_req", {31'b0, rd_burst_req}, 32'd1);
        check("r200_rd_addr", {4'b0, rd_burst_addr}, 32'h0001000);
        for (int k = 0; k < 7; k++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data       = 16'h5000 + 16'(k);
            step();
            rd_burst_data_valid = 1'b0;
        end
        rd_burst_data_valid = 1'b1;
        rd_burst_data       = 16'h5007;
        #2 rst = 1'b0;
        step();
        rd_burst_data_valid = 1'b0;
        check("midrst_rdy", {31'b0, data_rdy}, 32'd1);
        check("midrst_rd_req", {31'b0, rd_burst_req}, 32'd0);
        check("midrst_tag", {16'b0, tag_data}, 32'd0);
        rst = 1'b1;
        step();

        // Line invalidated: same address misses again
        request(1'b0, 16'h0200, 16'h0);
        step();
        check("postrst_miss", {31'b0, rd_burst_req}, 32'd1);
        refill(28'h0001000, 16'h4000, 0, 0);
        step();
        check("postrst_data", {16'b0, data_out}, 32'h4000);
        step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
